// File: rtl/encoder_pkg.sv
// Shared types and constants for the rotary-encoder reader.
// Combinational definitions only: no latency, no flow control.
package encoder_pkg;

    localparam int CNT_W      = 16;
    localparam int BYTE_W     = 8;
    localparam int PERIOD_DEF = 50000;
    localparam int LOCK_W_DEF = 2;
    localparam int SETTLE_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        LWAIT,
        CSHI,
        CSLO,
        DONE
    } state_t;

    // Dwell counter counts down to zero, so an n-cycle stay loads n-1.
    function automatic logic [CNT_W-1:0] dwell_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/encoder_reader_if.sv
// Decoder-side byte bus plus the assembled result presented to the application.
// Wires only: no latency; the result side has no backpressure (valid is a pulse).
interface encoder_reader_if;
    import encoder_pkg::*;

    logic              lock;
    logic              cs;
    logic [BYTE_W-1:0] data8;
    logic [CNT_W-1:0]  value;
    logic [CNT_W-1:0]  delta;
    logic              moved;
    logic              valid;

    modport master (
        output lock, cs, value, delta, moved, valid,
        input  data8
    );

    modport slave (
        input  lock, cs, value, delta, moved, valid,
        output data8
    );

endinterface

// File: rtl/encoder_reader_tick_gen.sv
// Free-running period timer: one-cycle tick every PERIOD cycles while en is high.
// Tick is combinational from the count; held at zero (no tick) while disabled.
module tick_gen #(
    parameter int PERIOD = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int            TW   = $clog2(PERIOD);
    localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

    logic [TW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/encoder_reader.sv
// Latches the encoder decoder, reads its count as two bytes and reports value/delta.
// start->valid latency is 1+LOCK_W+2+2*SETTLE cycles; start and ticks while busy are dropped.
module encoder_reader
    import encoder_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int LOCK_W = LOCK_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             auto_en,
    output logic             busy,
    encoder_reader_if.master bus
);
    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   dwell;
    logic [CNT_W-1:0]   dwell_nxt;
    logic [BYTE_W-1:0]  hi_byte;
    logic [CNT_W-1:0]   sample;
    logic               tick;
    logic               last;

    tick_gen #(.PERIOD(PERIOD)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (auto_en),
        .tick  (tick)
    );

    assign sample = {hi_byte, bus.data8};
    assign last   = (dwell == '0);

    always_comb begin
        state_nxt = state;
        dwell_nxt = '0;
        bus.lock  = 1'b0;
        bus.cs    = 1'b0;
        bus.valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // A start coinciding with a tick still yields a single read.
                if (start || tick) begin
                    state_nxt = LOCK;
                    dwell_nxt = dwell_load(LOCK_W);
                end
            end
            LOCK: begin
                bus.lock = 1'b1;
                if (last) begin
                    state_nxt = LWAIT;
                    dwell_nxt = dwell_load(2);
                end else begin
                    dwell_nxt = dwell - CNT_W'(1);
                end
            end
            LWAIT: begin
                if (last) begin
                    state_nxt = CSHI;
                    dwell_nxt = dwell_load(SETTLE);
                end else begin
                    dwell_nxt = dwell - CNT_W'(1);
                end
            end
            CSHI: begin
                bus.cs = 1'b1;
                if (last) begin
                    state_nxt = CSLO;
                    dwell_nxt = dwell_load(SETTLE);
                end else begin
                    dwell_nxt = dwell - CNT_W'(1);
                end
            end
            CSLO: begin
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    dwell_nxt = dwell - CNT_W'(1);
                end
            end
            DONE: begin
                bus.valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dwell     <= '0;
            hi_byte   <= '0;
            bus.value <= '0;
            bus.delta <= '0;
            bus.moved <= 1'b0;
        end else begin
            state <= state_nxt;
            dwell <= dwell_nxt;
            if (state == CSHI && last) begin
                hi_byte <= bus.data8;
            end
            // Low byte goes straight into value; delta wraps mod 2^16.
            if (state == CSLO && last) begin
                bus.value <= sample;
                bus.delta <= sample - bus.value;
                bus.moved <= (sample != bus.value);
            end
        end
    end

endmodule
